// File: rtl/rtc_bus_pkg.sv
// RTC bus reader shared definitions.
// State encoding, default phase timings, RTC register map.
package rtc_bus_pkg;

  localparam int T_ADDR_DEF = 4;
  localparam int T_GAP_DEF  = 3;
  localparam int T_RD_DEF   = 4;

  localparam logic [7:0] RTC_CTRL  = 8'h00;
  localparam logic [7:0] RTC_SEC   = 8'h01;
  localparam logic [7:0] RTC_MIN   = 8'h02;
  localparam logic [7:0] RTC_HOUR  = 8'h03;
  localparam logic [7:0] RTC_DAY   = 8'h04;
  localparam logic [7:0] RTC_DATE  = 8'h05;
  localparam logic [7:0] RTC_MONTH = 8'h06;
  localparam logic [7:0] RTC_YEAR  = 8'h07;

  typedef enum logic [3:0] {
    IDLE, A_AD, A_CS, A_WR,
    A_HOLD, A_WRH, A_CSH, A_ADH,
    A_FLT, GAP, D_CS, D_RD,
    D_END, D_CSH, NEXT, DONE
  } rtc_state_e;

endpackage

// File: rtl/rtc_bus_reader_if.sv
// Multiplexed address/data bus of the RTC chip.
// master = bus reader, slave = chip side.
interface rtc_bus_reader_if;
  logic       ad;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [7:0] ADout;
  logic       ADoe;
  logic [7:0] ADin;

  modport master (
    output ad, cs, wr, rd, ADout, ADoe,
    input  ADin
  );

  modport slave (
    input  ad, cs, wr, rd, ADout, ADoe,
    output ADin
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with zero flag.
// Times the address hold, gap and read phases.
module rtc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Burst reader for the RTC multiplexed bus.
// RTC_BCD_CHECK_EN adds bcd_err flagging non-BCD bytes.
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int T_ADDR = T_ADDR_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_RD   = T_RD_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [3:0] len,
  output logic       busy,
  output logic       rd_valid,
  output logic [3:0] rd_index,
  output logic [7:0] rd_data,
  output logic       done,
`ifdef RTC_BCD_CHECK_EN
  output logic       bcd_err,
`endif
  rtc_bus_reader_if.master bus
);

  localparam logic [7:0] LD_ADDR = 8'(T_ADDR - 1);
  localparam logic [7:0] LD_GAP  = 8'(T_GAP - 1);
  localparam logic [7:0] LD_RD   = 8'(T_RD - 1);

  rtc_state_e state, nxt;

  logic [7:0] addr;
  logic [3:0] len_q;
  logic       last;
  logic       t_load;
  logic [7:0] t_val;
  logic       t_zero;
  logic       ad_n, cs_n, wr_n, rd_n, oe_n;

  rtc_phase_timer #(.W(8)) u_tmr (
    .clock (clock),
    .reset (reset),
    .load  (t_load),
    .val   (t_val),
    .zero  (t_zero)
  );

  assign last = (rd_index == len_q - 4'd1);

  always_comb begin
    nxt    = state;
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      IDLE:   if (start) nxt = (len == 4'd0) ? DONE : A_AD;
      A_AD:   nxt = A_CS;
      A_CS:   nxt = A_WR;
      A_WR: begin
        nxt    = A_HOLD;
        t_load = 1'b1;
        t_val  = LD_ADDR;
      end
      A_HOLD: if (t_zero) nxt = A_WRH;
      A_WRH:  nxt = A_CSH;
      A_CSH:  nxt = A_ADH;
      A_ADH:  nxt = A_FLT;
      A_FLT: begin
        if (T_GAP == 0) begin
          nxt = D_CS;
        end else begin
          nxt    = GAP;
          t_load = 1'b1;
          t_val  = LD_GAP;
        end
      end
      GAP:    if (t_zero) nxt = D_CS;
      D_CS: begin
        nxt    = D_RD;
        t_load = 1'b1;
        t_val  = LD_RD;
      end
      D_RD:   if (t_zero) nxt = D_END;
      D_END:  nxt = D_CSH;
      D_CSH:  nxt = NEXT;
      // NEXT doubles as the address-strobe cycle of the following byte
      NEXT:   nxt = last ? DONE : A_CS;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign ad_n = !((nxt inside {A_AD, A_CS, A_WR, A_HOLD, A_WRH, A_CSH})
                  || (nxt == NEXT && !last));
  assign cs_n = !(nxt inside {A_CS, A_WR, A_HOLD, A_WRH,
                              D_CS, D_RD, D_END});
  assign wr_n = !(nxt inside {A_WR, A_HOLD});
  assign rd_n = (nxt != D_RD);
  assign oe_n = (nxt inside {A_WR, A_HOLD, A_WRH});

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      len_q     <= '0;
      rd_index  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bus.ad    <= 1'b1;
      bus.cs    <= 1'b1;
      bus.wr    <= 1'b1;
      bus.rd    <= 1'b1;
      bus.ADoe  <= 1'b0;
      bus.ADout <= '0;
    end else begin
      state    <= nxt;
      rd_valid <= (nxt == D_CSH);
      done     <= (nxt == DONE);
      busy     <= (nxt != IDLE) && (nxt != DONE);
      bus.ad   <= ad_n;
      bus.cs   <= cs_n;
      bus.wr   <= wr_n;
      bus.rd   <= rd_n;
      bus.ADoe <= oe_n;
      if (nxt == A_WR)
        bus.ADout <= addr;
      if (state == IDLE && start) begin
        addr     <= base_addr;
        len_q    <= len;
        rd_index <= '0;
      end
      if (state == NEXT && !last) begin
        addr     <= addr + 8'd1;
        rd_index <= rd_index + 4'd1;
      end
      if (state == D_RD && t_zero)
        rd_data <= bus.ADin;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset)
      bcd_err <= 1'b0;
    else
      bcd_err <= (nxt == D_CSH) &&
                 ((rd_data[7:4] > 4'd9) || (rd_data[3:0] > 4'd9));
  end
`endif

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Self-checking bench for rtc_bus_reader.
// Bus model serves a random register file; bursts checked against timing rules.
module tb_rtc_bus_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [3:0] len = '0;
  logic       busy, rd_valid, done;
  logic [3:0] rd_index;
  logic [7:0] rd_data;
  logic       bcd_w;

  rtc_bus_reader_if bus ();

`ifdef RTC_BCD_CHECK_EN
  logic bcd_err;
  assign bcd_w = bcd_err;
`else
  assign bcd_w = 1'b0;
`endif

  rtc_bus_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .done      (done),
`ifdef RTC_BCD_CHECK_EN
    .bcd_err   (bcd_err),
`endif
    .bus       (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [3:0] i;
    logic       e;
  } rv_t;

  logic [7:0] mem [256];
  logic [7:0] cur_addr = '0;
  logic       prev_wr = 1'b1;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         viol = 0;
  int         cs_low = 0;
  rv_t        rv_q [$];
  logic [7:0] addr_q [$];
  int         done_q [$];

  assign bus.ADin = mem[cur_addr];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (!bus.wr && prev_wr) addr_q.push_back(bus.ADout);
      if (!bus.wr) cur_addr = bus.ADout;
      if (rd_valid) rv_q.push_back('{cyc, rd_data, rd_index, bcd_w});
      if (done) done_q.push_back(cyc);
      if (!bus.cs) cs_low++;
      if (!bus.wr && !bus.rd) viol++;
      if (!bus.rd && bus.ADoe) viol++;
      if (bus.ADoe && (bus.cs || bus.ad)) viol++;
    end
    prev_wr = bus.wr;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic not_bcd(input logic [7:0] d);
    return ((int'(d) / 16) > 9) || ((int'(d) % 16) > 9);
  endfunction

  task automatic burst(input logic [7:0] b, input logic [3:0] l,
                       input bit repulse);
    int s;
    int lim;
    logic [7:0] a;
    addr_q.delete();
    rv_q.delete();
    done_q.delete();
    viol = 0;
    cs_low = 0;
    @(negedge clock);
    base_addr = b;
    len = l;
    start = 1'b1;
    s = cyc;
    @(negedge clock);
    start = 1'b0;
    base_addr = 8'($urandom);
    len = 4'($urandom);
    chk("busy_after_start", 32'(busy), 32'(l != 4'd0));
    lim = 21 * int'(l) + 4;
    for (int i = 0; i < lim && done_q.size() == 0; i++) begin
      start = repulse && (i == 8);
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_seen", 32'(done_q.size() != 0), 32'd1);
    if (done_q.size() == 0) return;
    repeat (3) @(negedge clock);
    chk("done_count", done_q.size(), 1);
    chk("done_cycle", done_q[0] - s, (l == 0) ? 1 : 21 * int'(l) + 2);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("n_bytes", rv_q.size(), int'(l));
    chk("n_addr", addr_q.size(), int'(l));
    chk("invariants", viol, 0);
    if (l == 4'd0) chk("cs_idle", cs_low, 0);
    for (int k = 0; k < int'(l) && k < rv_q.size(); k++) begin
      a = b + 8'(k);
      if (k < addr_q.size()) chk("addr", addr_q[k], a);
      chk("valid_cycle", rv_q[k].cyc - s, 21 + 21 * k);
      chk("data", rv_q[k].d, mem[a]);
      chk("index", rv_q[k].i, k);
`ifdef RTC_BCD_CHECK_EN
      chk("bcd_err", 32'(rv_q[k].e), 32'(not_bcd(mem[a])));
`endif
    end
  endtask

  initial begin
    int s;
    logic [7:0] rb;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clock);
    chk("rst_ad", 32'(bus.ad), 32'd1);
    chk("rst_cs", 32'(bus.cs), 32'd1);
    chk("rst_wr", 32'(bus.wr), 32'd1);
    chk("rst_rd", 32'(bus.rd), 32'd1);
    chk("rst_oe", 32'(bus.ADoe), 32'd0);
    chk("rst_adout", bus.ADout, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", rd_data, 0);
    chk("rst_index", rd_index, 0);
    reset = 1'b0;

    mem[8'h00] = 8'h59;
    burst(8'h00, 4'd1, 1'b0);

    mem[8'h02] = 8'h12;
    mem[8'h03] = 8'h34;
    mem[8'h04] = 8'h56;
    burst(8'h02, 4'd3, 1'b0);

    burst(8'hFE, 4'd3, 1'b0);
    burst(8'h40, 4'd0, 1'b0);
    burst(8'h20, 4'd2, 1'b1);

    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      burst(rb, 4'($urandom_range(1, 4)), r[0]);
    end

    mem[8'h30] = 8'h5A;
    burst(8'h30, 4'd1, 1'b0);

    @(negedge clock);
    base_addr = 8'h10;
    len = 4'd2;
    start = 1'b1;
    s = cyc;
    @(negedge clock);
    start = 1'b0;
    while (cyc < s + 17) @(negedge clock);
    chk("rd_low_in_drd", 32'(bus.rd), 32'd0);
    rv_q.delete();
    done_q.delete();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_rd", 32'(bus.rd), 32'd1);
    chk("mid_rst_cs", 32'(bus.cs), 32'd1);
    chk("mid_rst_ad", 32'(bus.ad), 32'd1);
    chk("mid_rst_oe", 32'(bus.ADoe), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    chk("post_rst_bytes", rv_q.size(), 0);
    chk("post_rst_done", done_q.size(), 0);
    chk("post_rst_cs", 32'(bus.cs), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
